// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite register slave.
package axil_pkg;

  localparam int unsigned AXIL_DATA_W = 32;
  localparam int unsigned AXIL_STRB_W = AXIL_DATA_W / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {WIdle, WResp} wr_state_t;
  typedef enum logic {RIdle, RData} rd_state_t;

endpackage

// File: rtl/axil_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R) with master and slave views.
interface axil_if import axil_pkg::*; #(
  parameter int unsigned ADDR_W = 32
) ();

  logic [ADDR_W-1:0]      awaddr;
  logic                   awvalid;
  logic                   awready;
  logic [AXIL_DATA_W-1:0] wdata;
  logic [AXIL_STRB_W-1:0] wstrb;
  logic                   wvalid;
  logic                   wready;
  resp_t                  bresp;
  logic                   bvalid;
  logic                   bready;
  logic [ADDR_W-1:0]      araddr;
  logic                   arvalid;
  logic                   arready;
  logic [AXIL_DATA_W-1:0] rdata;
  resp_t                  rresp;
  logic                   rvalid;
  logic                   rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_regfile.sv
// Register storage with byte-strobed write port and combinational read mux.
module axil_regfile import axil_pkg::*; #(
  parameter int unsigned             NUM_REGS  = 16,
  parameter logic [AXIL_DATA_W-1:0]  RESET_VAL = '0,
  localparam int unsigned            IdxW      = $clog2(NUM_REGS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            we,
  input  logic [IdxW-1:0]                 widx,
  input  logic [AXIL_DATA_W-1:0]          wdata,
  input  logic [AXIL_STRB_W-1:0]          wstrb,
  input  logic [IdxW-1:0]                 ridx,
  output logic [AXIL_DATA_W-1:0]          rdata,
  output logic [AXIL_DATA_W*NUM_REGS-1:0] regs_o
);

  logic [NUM_REGS-1:0][AXIL_DATA_W-1:0] regs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= {NUM_REGS{RESET_VAL}};
    end else if (we) begin
      for (int b = 0; b < AXIL_STRB_W; b++) begin
        if (wstrb[b]) regs_q[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read sees the pre-edge contents, so a same-cycle write is not forwarded.
  assign rdata  = regs_q[ridx];
  assign regs_o = regs_q;

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave register bank with independent write/read channel FSMs.
// Optional AXIL_SLV_ERR_RESP_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi4_lite_reg_slave import axil_pkg::*; #(
  parameter int unsigned            NUM_REGS  = 16,
  parameter int unsigned            ADDR_W    = 32,
  parameter logic [AXIL_DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  axil_if.slave                           s_axi,
  output logic [AXIL_DATA_W*NUM_REGS-1:0] regs_o,
  output logic [NUM_REGS-1:0]             wr_pulse_o
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);

`ifdef AXIL_SLV_ERR_RESP_EN
  localparam resp_t OorResp = SLVERR;
`else
  localparam resp_t OorResp = OKAY;
`endif

  function automatic logic in_range(logic [ADDR_W-1:0] addr);
    return (addr >> 2) < ADDR_W'(NUM_REGS);
  endfunction

  // Write channel
  wr_state_t              wr_state_q, wr_state_d;
  logic                   aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [ADDR_W-1:0]      awaddr_q, awaddr_d;
  logic [AXIL_DATA_W-1:0] wdata_q, wdata_d;
  logic [AXIL_STRB_W-1:0] wstrb_q, wstrb_d;
  resp_t                  bresp_q, bresp_d;
  logic [NUM_REGS-1:0]    wr_pulse_q, wr_pulse_d;

  logic                   aw_hs, w_hs, wr_fire, wr_ok, reg_we;
  logic [ADDR_W-1:0]      wr_addr;
  logic [AXIL_DATA_W-1:0] wr_data;
  logic [AXIL_STRB_W-1:0] wr_strb;
  logic [IdxW-1:0]        wr_idx;

  assign s_axi.awready = (wr_state_q == WIdle) && !aw_got_q;
  assign s_axi.wready  = (wr_state_q == WIdle) && !w_got_q;
  assign s_axi.bvalid  = (wr_state_q == WResp);
  assign s_axi.bresp   = bresp_q;

  assign aw_hs   = s_axi.awvalid && s_axi.awready;
  assign w_hs    = s_axi.wvalid && s_axi.wready;
  // A channel captured earlier is used from its holding register, else straight from the bus.
  assign wr_addr = aw_got_q ? awaddr_q : s_axi.awaddr;
  assign wr_data = w_got_q ? wdata_q : s_axi.wdata;
  assign wr_strb = w_got_q ? wstrb_q : s_axi.wstrb;
  assign wr_fire = (aw_got_q || aw_hs) && (w_got_q || w_hs);
  assign wr_ok   = in_range(wr_addr);
  assign wr_idx  = wr_addr[IdxW+1:2];
  assign reg_we  = wr_fire && wr_ok;

  always_comb begin
    wr_state_d = wr_state_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    unique case (wr_state_q)
      WIdle: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          awaddr_d = s_axi.awaddr;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = s_axi.wdata;
          wstrb_d = s_axi.wstrb;
        end
        if (wr_fire) begin
          wr_state_d = WResp;
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
          bresp_d    = wr_ok ? OKAY : OorResp;
          if (wr_ok) wr_pulse_d[wr_idx] = 1'b1;
        end
      end
      WResp: begin
        if (s_axi.bready) wr_state_d = WIdle;
      end
      default: wr_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WIdle;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= OKAY;
      wr_pulse_q <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  assign wr_pulse_o = wr_pulse_q;

  // Read channel
  rd_state_t              rd_state_q, rd_state_d;
  logic [AXIL_DATA_W-1:0] rdata_q, rdata_d, rf_rdata;
  resp_t                  rresp_q, rresp_d;
  logic                   ar_hs, rd_ok;
  logic [IdxW-1:0]        rd_idx;

  assign s_axi.arready = (rd_state_q == RIdle);
  assign s_axi.rvalid  = (rd_state_q == RData);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign ar_hs  = s_axi.arvalid && s_axi.arready;
  assign rd_ok  = in_range(s_axi.araddr);
  assign rd_idx = s_axi.araddr[IdxW+1:2];

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      RIdle: begin
        if (ar_hs) begin
          rd_state_d = RData;
          rdata_d    = rd_ok ? rf_rdata : '0;
          rresp_d    = rd_ok ? OKAY : OorResp;
        end
      end
      RData: begin
        if (s_axi.rready) rd_state_d = RIdle;
      end
      default: rd_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= RIdle;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  axil_regfile #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (reg_we),
    .widx   (wr_idx),
    .wdata  (wr_data),
    .wstrb  (wr_strb),
    .ridx   (rd_idx),
    .rdata  (rf_rdata),
    .regs_o (regs_o)
  );

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Randomized self-checking bench for axi4_lite_reg_slave against an array model.
module tb_axi4_lite_reg_slave;
  import axil_pkg::*;

  localparam int unsigned NRegs = 16;
`ifdef AXIL_SLV_ERR_RESP_EN
  localparam logic [31:0] OorResp = 32'd2;
`else
  localparam logic [31:0] OorResp = 32'd0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [32*NRegs-1:0]   regs;
  logic [NRegs-1:0]      wr_pulse;
  logic [31:0]           model [NRegs];
  int                    n_chk = 0;
  int                    n_err = 0;

  axil_if #(.ADDR_W(32)) bus ();

  axi4_lite_reg_slave #(
    .NUM_REGS  (NRegs),
    .ADDR_W    (32),
    .RESET_VAL (32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_axi      (bus),
    .regs_o     (regs),
    .wr_pulse_o (wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] addr);
    return (addr >> 2) < NRegs;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < NRegs; i++) check(tag, regs[32*i +: 32], model[i]);
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int t = 0;
    logic [31:0] exp_resp, exp_pulse;
    bus.bready = 1'b0;
    while (!(aw_done && w_done)) begin
      bus.awaddr  = addr;
      bus.awvalid = !aw_done && (t >= aw_dly);
      bus.wdata   = data;
      bus.wstrb   = strb;
      bus.wvalid  = !w_done && (t >= w_dly);
      @(negedge clk);
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(posedge clk);
      #1;
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      if (w_done && !aw_done) check("wready_after_w", bus.wready, 0);
      if (aw_done && !w_done) check("awready_after_aw", bus.awready, 0);
      t++;
      if (t > 40) begin
        check("write_timeout", 0, 1);
        bus.awvalid = 0;
        bus.wvalid  = 0;
        return;
      end
    end
    bus.awvalid = 0;
    bus.wvalid  = 0;
    if (in_rng(addr)) begin
      model[int'(addr >> 2)] = merge(model[int'(addr >> 2)], data, strb);
      exp_resp  = 0;
      exp_pulse = 32'd1 << (addr >> 2);
    end else begin
      exp_resp  = OorResp;
      exp_pulse = 0;
    end
    check("bvalid", bus.bvalid, 1);
    check("bresp", bus.bresp, exp_resp);
    check("wr_pulse", 32'(wr_pulse), exp_pulse);
    check_regs("regs_after_write");
    bus.awvalid = 1'b1;
    bus.awaddr  = 32'h0;
    for (int i = 0; i < b_dly; i++) begin
      @(posedge clk);
      #1;
      check("bvalid_hold", bus.bvalid, 1);
      check("bresp_hold", bus.bresp, exp_resp);
      check("awready_in_resp", bus.awready, 0);
      check("wready_in_resp", bus.wready, 0);
      check("wr_pulse_once", 32'(wr_pulse), 0);
    end
    bus.bready = 1'b1;
    @(posedge clk);
    #1;
    bus.bready  = 1'b0;
    bus.awvalid = 1'b0;
    check("bvalid_done", bus.bvalid, 0);
    check("awready_back", bus.awready, 1);
    check("wready_back", bus.wready, 1);
    check("wr_pulse_clear", 32'(wr_pulse), 0);
    check_regs("regs_after_b");
  endtask

  task automatic do_read(input logic [31:0] addr, input int r_dly, output logic [31:0] got);
    bit hs = 0;
    int t = 0;
    logic [31:0] exp_d = 0, exp_r = 0;
    bus.rready  = 1'b0;
    bus.arvalid = 1'b1;
    bus.araddr  = addr;
    while (!hs) begin
      @(negedge clk);
      hs = bus.arvalid && bus.arready;
      if (hs) begin
        exp_d = in_rng(addr) ? model[int'(addr >> 2)] : 32'h0;
        exp_r = in_rng(addr) ? 32'd0 : OorResp;
      end
      @(posedge clk);
      #1;
      t++;
      if (!hs && t > 20) begin
        check("read_timeout", 0, 1);
        bus.arvalid = 0;
        got = 0;
        return;
      end
    end
    bus.arvalid = 1'b0;
    got = bus.rdata;
    check("rvalid", bus.rvalid, 1);
    check("rdata", bus.rdata, exp_d);
    check("rresp", bus.rresp, exp_r);
    for (int i = 0; i < r_dly; i++) begin
      @(posedge clk);
      #1;
      check("rvalid_hold", bus.rvalid, 1);
      check("rdata_hold", bus.rdata, exp_d);
      check("arready_in_data", bus.arready, 0);
    end
    bus.rready = 1'b1;
    @(posedge clk);
    #1;
    bus.rready = 1'b0;
    check("rvalid_done", bus.rvalid, 0);
    check("arready_back", bus.arready, 1);
  endtask

  logic [31:0] rd, addr;

  initial begin
    rst = 1'b1;
    bus.awaddr = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0;
    bus.bready = 0; bus.araddr = 0; bus.arvalid = 0; bus.rready = 0;
    for (int i = 0; i < NRegs; i++) model[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", bus.awready, 1);
    check("rst_wready", bus.wready, 1);
    check("rst_arready", bus.arready, 1);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_pulse", 32'(wr_pulse), 0);
    check_regs("rst_regs");
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check("t1_reg2", regs[32*2 +: 32], 32'hDEADBEEF);
    do_write(32'h04, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    do_write(32'h04, 32'h11223344, 4'b0101, 3, 0, 0);
    check("t2_reg1", regs[32*1 +: 32], 32'hAA22CC44);
    do_write(32'h13, 32'h12345678, 4'hF, 0, 2, 5);
    do_read(32'h08, 4, rd);
    check("t4_rdata", rd, 32'hDEADBEEF);
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, 1, 0, 1);
    do_read(32'h44, 0, rd);
    check("t5_rdata", rd, 32'h0);

    // Read and write of reg3 accepted on the same edge.
    do_write(32'h0C, 32'h0BADF00D, 4'hF, 0, 0, 0);
    bus.awaddr = 32'h0C; bus.awvalid = 1; bus.wdata = 32'h600DCAFE; bus.wstrb = 4'hF;
    bus.wvalid = 1; bus.araddr = 32'h0C; bus.arvalid = 1;
    @(posedge clk);
    #1;
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    model[3] = 32'h600DCAFE;
    check("rw_same_rdata", bus.rdata, 32'h0BADF00D);
    check("rw_same_bvalid", bus.bvalid, 1);
    check("rw_same_rvalid", bus.rvalid, 1);
    check("rw_same_reg", regs[32*3 +: 32], model[3]);
    bus.bready = 1; bus.rready = 1;
    @(posedge clk);
    #1;
    bus.bready = 0; bus.rready = 0;
    check("rw_same_done", {31'h0, bus.bvalid | bus.rvalid}, 0);

    for (int it = 0; it < 60; it++) begin
      addr = ($urandom_range(0, NRegs + 3) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1)
        do_write(addr, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2));
      else
        do_read(addr, $urandom_range(0, 2), rd);
    end

    // Reset with both responses outstanding.
    bus.awaddr = 32'h1C; bus.awvalid = 1; bus.wdata = 32'hCAFEBABE; bus.wstrb = 4'hF;
    bus.wvalid = 1; bus.araddr = 32'h08; bus.arvalid = 1;
    @(posedge clk);
    #1;
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    check("pre_rst_bvalid", bus.bvalid, 1);
    check("pre_rst_rvalid", bus.rvalid, 1);
    rst = 1'b1;
    for (int i = 0; i < NRegs; i++) model[i] = 32'h0;
    @(posedge clk);
    #1;
    check("mid_rst_bvalid", bus.bvalid, 0);
    check("mid_rst_rvalid", bus.rvalid, 0);
    check("mid_rst_awready", bus.awready, 1);
    check("mid_rst_wready", bus.wready, 1);
    check("mid_rst_arready", bus.arready, 1);
    check_regs("mid_rst_regs");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_bvalid", bus.bvalid, 0);
    do_write(32'h20, 32'h01020304, 4'b1001, 0, 1, 1);
    do_read(32'h20, 1, rd);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
